// File: rtl/ddram_bram_responder.sv
// ddram_bram_responder: Avalon-style DDRAM command responder backed by an
// on-chip BRAM window of 2^ADDR_BITS 64-bit words at BASE.
// Optional feature: define DDRAM_RESP_BUSY_INJECT_EN to let a 16-bit LFSR
// randomly hold BUSY high while idle or mid write burst.
module ddram_bram_responder #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter logic [28:0] BASE       = 29'h0C000000,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  output logic        err_oob,
  output logic        err_proto
);

  localparam int unsigned DEPTH     = 1 << ADDR_BITS;
  localparam logic [2:0]  WAIT_INIT = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

  state_t                 state;
  logic [63:0]            mem [DEPTH] = '{default: '0};
  logic [ADDR_BITS-1:0]   idx;
  logic [ADDR_BITS-1:0]   in_idx;
  logic [ADDR_BITS-1:0]   wr_idx;
  logic                   hit_r;
  logic                   in_hit;
  logic [7:0]             cnt_in;
  logic [7:0]             left;
  logic [2:0]             wait_cnt;
  logic                   wr_en;
  logic                   stall_next;

  assign in_idx = DDRAM_ADDR[ADDR_BITS-1:0];
  assign in_hit = (DDRAM_ADDR >> ADDR_BITS) == (BASE >> ADDR_BITS);
  assign cnt_in = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;

`ifdef DDRAM_RESP_BUSY_INJECT_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  // Fibonacci LFSR, taps 16,14,13,11; low two bits of the next value decide a stall
  always_comb begin
    lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    stall_next = (lfsr_next[1:0] == 2'b00);
  end

  // LFSR state register
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= lfsr_next;
  end
`else
  assign stall_next = 1'b0;
`endif

  // Write-port decode: beat 0 comes straight from the command, later beats
  // from the latched burst address; reset blocks any write in flight
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = in_idx;
    if (!reset && !DDRAM_BUSY && DDRAM_WE) begin
      case (state)
        IDLE:     wr_en = in_hit;
        WR_BURST: begin
          wr_en  = hit_r;
          wr_idx = idx;
        end
        default: ;
      endcase
    end
  end

  // BRAM write port, byte-enable gated; contents survive reset
  always_ff @(posedge DDRAM_CLK) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (DDRAM_BE[i]) mem[wr_idx][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
      end
    end
  end

  // Command FSM with registered BUSY, read data and error flags
  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state            <= IDLE;
      DDRAM_BUSY       <= 1'b0;
      DDRAM_DOUT_READY <= 1'b0;
      DDRAM_DOUT       <= '0;
      err_oob          <= 1'b0;
      err_proto        <= 1'b0;
      idx              <= '0;
      hit_r            <= 1'b0;
      left             <= '0;
      wait_cnt         <= '0;
    end else begin
      DDRAM_DOUT_READY <= 1'b0;
      err_oob          <= 1'b0;
      case (state)
        IDLE: begin
          DDRAM_BUSY <= stall_next;
          if (!DDRAM_BUSY && DDRAM_WE) begin
            err_oob <= !in_hit;
            if (DDRAM_RD) err_proto <= 1'b1;
            hit_r <= in_hit;
            idx   <= in_idx + 1'b1;
            left  <= cnt_in - 8'd1;
            if (cnt_in > 8'd1) state <= WR_BURST;
          end else if (!DDRAM_BUSY && DDRAM_RD) begin
            err_oob    <= !in_hit;
            hit_r      <= in_hit;
            DDRAM_BUSY <= 1'b1;
            // With single-cycle latency the first beat is produced at the
            // accept edge itself, so RD_WAIT is skipped
            if (RD_LATENCY <= 1) begin
              DDRAM_DOUT_READY <= 1'b1;
              DDRAM_DOUT       <= in_hit ? mem[in_idx] : '0;
              idx              <= in_idx + 1'b1;
              left             <= cnt_in - 8'd1;
              state            <= RD_BURST;
            end else begin
              idx      <= in_idx;
              left     <= cnt_in;
              wait_cnt <= WAIT_INIT;
              state    <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 3'd1) begin
            DDRAM_DOUT_READY <= 1'b1;
            DDRAM_DOUT       <= hit_r ? mem[idx] : '0;
            idx              <= idx + 1'b1;
            left             <= left - 8'd1;
            state            <= RD_BURST;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RD_BURST: begin
          // left==0 here means the last beat went out on the previous edge
          if (left == 8'd0) begin
            DDRAM_BUSY <= stall_next;
            state      <= IDLE;
          end else begin
            DDRAM_DOUT_READY <= 1'b1;
            DDRAM_DOUT       <= hit_r ? mem[idx] : '0;
            idx              <= idx + 1'b1;
            left             <= left - 8'd1;
          end
        end
        WR_BURST: begin
          DDRAM_BUSY <= stall_next;
          if (DDRAM_RD) err_proto <= 1'b1;
          if (!DDRAM_BUSY && DDRAM_WE) begin
            idx  <= idx + 1'b1;
            left <= left - 8'd1;
            if (left == 8'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Scoreboard bench for ddram_bram_responder: the driver pushes expected read
// beats (data and cycle) from a word-array reference model; a negedge
// monitor pops and compares each DOUT_READY beat.
module tb_ddram_bram_responder;

  localparam int unsigned AB    = 12;
  localparam logic [28:0] BASE_A = 29'h0C000000;
  localparam int unsigned LAT   = 2;
  localparam int unsigned WORDS = 1 << AB;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [7:0]  burstcnt;
  logic [28:0] addr;
  logic        rd;
  logic        we;
  logic [63:0] din;
  logic [7:0]  be;
  logic [63:0] dout;
  logic        dout_ready;
  logic        err_oob;
  logic        err_proto;

  ddram_bram_responder #(
    .ADDR_BITS(AB),
    .BASE(BASE_A),
    .RD_LATENCY(LAT)
  ) dut (
    .DDRAM_CLK(clk),
    .reset(reset),
    .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(burstcnt),
    .DDRAM_ADDR(addr),
    .DDRAM_RD(rd),
    .DDRAM_WE(we),
    .DDRAM_DIN(din),
    .DDRAM_BE(be),
    .DDRAM_DOUT(dout),
    .DDRAM_DOUT_READY(dout_ready),
    .err_oob(err_oob),
    .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int unsigned cyc;
  } beat_t;

  beat_t       expq[$];
  logic [63:0] ref_mem [WORDS];
  logic [63:0] wd[$];
  logic [7:0]  wbe[$];
  int unsigned cyc = 0;
  int unsigned beats_seen = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_win(input logic [28:0] a);
    return (a >> AB) == (BASE_A >> AB);
  endfunction

  function automatic int unsigned word_of(input logic [28:0] a, input int unsigned k);
    return (int'(a % WORDS) + k) % WORDS;
  endfunction

  // Monitor: every returned beat must match the oldest expectation
  beat_t e;
  always @(negedge clk) begin
    if (!reset && dout_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got DOUT_READY with data %h, expected none (cycle %0d)", dout, cyc);
      end else begin
        e = expq.pop_front();
        check("beat_data", dout, e.data);
        check("beat_cycle", 64'(cyc), 64'(e.cyc));
        beats_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("busy_wait", {63'd0, busy}, 64'd0);
  endtask

  // Write burst using wd/wbe; optional stall cycles and RD on beat 0
  task automatic wr_burst(input logic [28:0] a, input int unsigned n, input bit stalls, input bit with_rd);
    int unsigned ne = (n == 0) ? 1 : n;
    int unsigned w;
    wait_idle();
    for (int unsigned b = 0; b < ne; b++) begin
      if (b > 0 && stalls) begin
        int unsigned s = $urandom_range(0, 2);
        we = 1'b0;
        for (int unsigned j = 0; j < s; j++) tick();
      end
      we       = 1'b1;
      rd       = (b == 0) ? with_rd : 1'b0;
      addr     = a;
      burstcnt = n[7:0];
      din      = wd[b];
      be       = wbe[b];
      for (int unsigned j = 0; j < 200 && busy; j++) tick();
      if (in_win(a)) begin
        w = word_of(a, b);
        for (int unsigned i = 0; i < 8; i++)
          if (wbe[b][i]) ref_mem[w][8*i +: 8] = wd[b][8*i +: 8];
      end
      tick();
      if (b == 0) check("err_oob_wr", {63'd0, err_oob}, {63'd0, !in_win(a)});
    end
    we = 1'b0;
    rd = 1'b0;
  endtask

  task automatic rd_burst(input logic [28:0] a, input int unsigned n);
    int unsigned ne = (n == 0) ? 1 : n;
    int unsigned c0;
    beat_t x;
    wait_idle();
    rd       = 1'b1;
    addr     = a;
    burstcnt = n[7:0];
    c0 = cyc + 1;
    for (int unsigned k = 0; k < ne; k++) begin
      x.data = in_win(a) ? ref_mem[word_of(a, k)] : 64'h0;
      x.cyc  = c0 + LAT - 1 + k;
      expq.push_back(x);
    end
    tick();
    rd = 1'b0;
    check("err_oob_rd", {63'd0, err_oob}, {63'd0, !in_win(a)});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hb;
    int unsigned base_seen;
    int unsigned stray;
    logic [28:0] a;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    reset = 1'b1; rd = 1'b0; we = 1'b0; addr = '0; burstcnt = '0; din = '0; be = '0;
    repeat (3) tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ready", {63'd0, dout_ready}, 64'd0);
    check("rst_dout", dout, 64'd0);
    check("rst_err_oob", {63'd0, err_oob}, 64'd0);
    check("rst_err_proto", {63'd0, err_proto}, 64'd0);
    reset = 1'b0;
    tick();

    // Single word write then read, full then partial byte enables
    wd = '{64'h1122334455667788}; wbe = '{8'hFF};
    wr_burst(29'h0C000005, 1, 1'b0, 1'b0);
    rd_burst(29'h0C000005, 1);
    wd = '{64'h00000000000000AA}; wbe = '{8'h01};
    wr_burst(29'h0C000005, 1, 1'b0, 1'b0);
    rd_burst(29'h0C000005, 1);
    wait_idle();
    check("be01_model", ref_mem[5], 64'h11223344556677AA);

    // Burst across the window wrap
    wd = '{64'd1, 64'd2, 64'd3, 64'd4}; wbe = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wr_burst(29'h0C000FFE, 4, 1'b0, 1'b0);
    rd_burst(29'h0C000FFE, 4);
    hb = 0;
    while (busy && hb < 50) begin hb++; tick(); end
    check("busy_len", 64'(hb), 64'd5);

    // Out-of-window read
    rd_burst(29'h00000010, 1);
    wait_idle();
    check("oob_err_proto", {63'd0, err_proto}, 64'd0);

    // Randomized traffic
    for (int unsigned t = 0; t < 80; t++) begin
      int unsigned n = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) begin
        a = 29'($urandom);
        if (in_win(a)) a[28] = ~a[28];
      end else if ($urandom_range(0, 3) == 0) begin
        a = BASE_A | 29'($urandom_range(WORDS - 6, WORDS - 1));
      end else begin
        a = BASE_A | 29'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 1) == 0) begin
        wd.delete(); wbe.delete();
        for (int unsigned b = 0; b < 7; b++) begin
          wd.push_back({$urandom, $urandom});
          wbe.push_back(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
        end
        wr_burst(a, n, 1'b1, 1'b0);
      end else begin
        rd_burst(a, n);
      end
    end
    wait_idle();
    check("rand_err_proto", {63'd0, err_proto}, 64'd0);

    // RD and WE together: write wins, err_proto sticks
    wd = '{64'hDEADBEEFCAFEF00D}; wbe = '{8'hFF};
    wr_burst(29'h0C000040, 1, 1'b0, 1'b1);
    repeat (3) tick();
    check("proto_set", {63'd0, err_proto}, 64'd1);
    rd_burst(29'h0C000040, 1);
    wait_idle();
    check("proto_sticky", {63'd0, err_proto}, 64'd1);

    // Reset in the middle of an 8-beat read
    wd.delete(); wbe.delete();
    for (int unsigned b = 0; b < 8; b++) begin
      wd.push_back(64'hA5A5000000000000 | 64'(b));
      wbe.push_back(8'hFF);
    end
    wr_burst(29'h0C000100, 8, 1'b0, 1'b0);
    base_seen = beats_seen;
    rd_burst(29'h0C000100, 8);
    for (int unsigned j = 0; j < 50 && beats_seen < base_seen + 2; j++) begin
      @(negedge clk);
      #1;
    end
    check("beats_before_reset", 64'(beats_seen - base_seen), 64'd2);
    reset = 1'b1;
    expq.delete();
    tick();
    tick();
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_ready", {63'd0, dout_ready}, 64'd0);
    check("mid_rst_proto", {63'd0, err_proto}, 64'd0);
    reset = 1'b0;
    stray = 0;
    for (int unsigned j = 0; j < 10; j++) begin
      if (dout_ready) stray++;
      tick();
    end
    check("no_beats_after_reset", 64'(stray), 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    rd_burst(29'h0C000100, 3);
    rd_burst(29'h0C000005, 1);
    wait_idle();
    repeat (10) tick();
    check("queue_drain", 64'(expq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
